// File: rtl/vu_pkg.sv
// Shared types and constants for the vector-unit result path.
package vu_pkg;
  localparam int RESULT_W = 8;
  localparam logic signed [RESULT_W-1:0] ARGMAX_INIT = 8'sh80;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } collector_state_t;
endpackage

// File: rtl/vu_result_ram.sv
// Layer result buffer: one synchronous write port, one registered read port,
// read-before-write on address collision. Storage itself is not reset.
module vu_result_ram import vu_pkg::*; #(
  parameter int NEURONS = 16,
  parameter int AW      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [AW-1:0]              waddr,
  input  logic signed [RESULT_W-1:0] wdata,
  input  logic                       rd_en,
  input  logic                       rd_zero,
  input  logic [AW-1:0]              raddr,
  output logic signed [RESULT_W-1:0] rd_data
);
  logic signed [RESULT_W-1:0] mem [NEURONS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Nonblocking read of mem gives the pre-write value on a same-address hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= rd_zero ? '0 : mem[raddr];
  end
endmodule

// File: rtl/vu_result_collector.sv
// Collects one layer of activated results into a local buffer, tracks the
// argmax for output layers, and serves the buffer through a registered read port.
module vu_result_collector import vu_pkg::*; #(
  parameter int NEURONS = 16,
  parameter int IDX_W   = $clog2(NEURONS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       output_layer,
  input  logic                       res_valid,
  input  logic signed [RESULT_W-1:0] result,
  output logic                       res_ready,
  input  logic                       rd_en,
  input  logic [IDX_W-1:0]           rd_addr,
  output logic signed [RESULT_W-1:0] rd_data,
  output logic                       rd_valid,
  output logic                       done,
  output logic [IDX_W:0]             count,
  output logic [IDX_W-1:0]           argmax_idx,
  output logic signed [RESULT_W-1:0] argmax_val
);
  localparam int AW    = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int CNT_W = IDX_W + 1;

  collector_state_t state;
  logic             ol_q;
  logic             accept;
  logic             rd_oor;

  // A start pulse always wins: no sample is taken in the restart cycle.
  assign res_ready = (state == COLLECT) && !start;
  assign accept    = res_valid && res_ready;
  assign rd_oor    = ({1'b0, rd_addr} >= CNT_W'(NEURONS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ol_q       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      argmax_idx <= '0;
      argmax_val <= ARGMAX_INIT;
    end else if (start) begin
      state      <= COLLECT;
      ol_q       <= output_layer;
      done       <= 1'b0;
      count      <= '0;
      argmax_idx <= '0;
      argmax_val <= ARGMAX_INIT;
    end else if (accept) begin
      count <= count + 1'b1;
      if (ol_q && (result > argmax_val)) begin
        argmax_val <= result;
        argmax_idx <= count[IDX_W-1:0];
      end
      if (count == CNT_W'(NEURONS - 1)) begin
        state <= DONE;
        done  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_valid <= 1'b0;
    else      rd_valid <= rd_en;
  end

  vu_result_ram #(.NEURONS(NEURONS), .AW(AW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (accept),
    .waddr   (count[AW-1:0]),
    .wdata   (result),
    .rd_en   (rd_en),
    .rd_zero (rd_oor),
    .raddr   (rd_addr[AW-1:0]),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_vu_result_collector.sv
// Randomized bench for vu_result_collector against a queue-based layer model.
module tb_vu_result_collector;
  localparam int N     = 16;
  localparam int IDX_W = 5;   // wide enough to address past the buffer end

  logic              clk = 1'b0;
  logic              rst;
  logic              start, output_layer, res_valid, res_ready, rd_en, rd_valid, done;
  logic signed [7:0] result, rd_data, argmax_val;
  logic [IDX_W-1:0]  rd_addr, argmax_idx;
  logic [IDX_W:0]    count;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model: 0 idle, 1 collecting, 2 layer complete
  int m_state;
  bit m_ol;
  int q[$];
  int mbuf[N];
  bit mknown[N];

  vu_result_collector #(.NEURONS(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .output_layer(output_layer),
    .res_valid(res_valid), .result(result), .res_ready(res_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .count(count), .argmax_idx(argmax_idx), .argmax_val(argmax_val)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, longint got, longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_state();
    int best, bidx;
    best = -128; bidx = 0;
    if (m_ol)
      foreach (q[i]) if (q[i] > best) begin best = q[i]; bidx = i; end
    chk("count", count, q.size());
    chk("done", done, m_state == 2);
    chk("argmax_idx", argmax_idx, bidx);
    chk("argmax_val", argmax_val, best);
  endtask

  // Called at posedge+1; drives one cycle and checks its outcome.
  task automatic cyc(bit st, bit ol, bit vl, int res, bit re, int ra);
    bit exp_rdy, acc, rd_chk;
    int exp_rd;
    start = st; output_layer = ol; res_valid = vl; result = 8'(res);
    rd_en = re; rd_addr = IDX_W'(ra);
    #1;
    exp_rdy = (m_state == 1) && !st;
    chk("res_ready", res_ready, exp_rdy);
    acc = vl && exp_rdy;
    @(posedge clk);
    rd_chk = 0; exp_rd = 0;
    if (re) begin
      if (ra >= N) begin exp_rd = 0; rd_chk = 1; end
      else if (mknown[ra]) begin exp_rd = mbuf[ra]; rd_chk = 1; end
    end
    if (st) begin
      m_state = 1; m_ol = ol; q.delete();
    end else if (acc) begin
      mbuf[q.size()] = res; mknown[q.size()] = 1;
      q.push_back(res);
      if (q.size() == N) m_state = 2;
    end
    #1;
    chk_state();
    chk("rd_valid", rd_valid, re);
    if (rd_chk) chk("rd_data", rd_data, exp_rd);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    start = 0; output_layer = 0; res_valid = 0; result = 0; rd_en = 0; rd_addr = 0;
    #2 rst = 1'b0;
    m_state = 0; m_ol = 0; q.delete();
    #1;
    chk_state();
    chk("rst_res_ready", res_ready, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
  endtask

  initial begin
    int vals[N];
    rst = 1'b0;
    start = 0; output_layer = 0; res_valid = 0; result = 0; rd_en = 0; rd_addr = 0;
    m_state = 0; m_ol = 0;
    foreach (mknown[i]) mknown[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_state();
    chk("init_rd_data", rd_data, 0);
    chk("init_rd_valid", rd_valid, 0);
    chk("init_res_ready", res_ready, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;

    // output layer, 0..15 back to back, then read everything back
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 1, i, 0, 0);
    chk("t1_done", done, 1);
    chk("t1_argmax_idx", argmax_idx, 15);
    chk("t1_argmax_val", argmax_val, 15);
    cyc(0, 0, 1, 99, 0, 0);     // no accept in DONE
    for (int i = 0; i < N; i++) cyc(0, 0, 0, 0, 1, i);
    idle(1);

    // gapped valid, ties and -128 tail
    vals[0] = 5; vals[1] = -3; vals[2] = 9; vals[3] = 9; vals[4] = 2;
    for (int i = 5; i < N - 1; i++) vals[i] = int'($urandom_range(0, 136)) - 128;
    vals[N-1] = -128;
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2 * N; i++) cyc(0, 0, i % 2 == 0, vals[i / 2], 0, 0);
    chk("t2_argmax_idx", argmax_idx, 2);
    chk("t2_argmax_val", argmax_val, 9);

    // non-output layer: argmax stays cleared
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 1, 127, 0, 0);
    idle(1);
    chk("t3_argmax_idx", argmax_idx, 0);
    chk("t3_argmax_val", argmax_val, -128);

    // abort after 7 accepts with res_valid high during the restart
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 100 + i, 0, 0);
    cyc(1, 1, 1, 55, 0, 0);
    chk("t4_count_clear", count, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 1, int'($urandom_range(0, 255)) - 128, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 0, 0, 1, i);

    // random traffic: random valid, random reads including out of range
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
          int'($urandom_range(0, 255)) - 128, $urandom_range(0, 1), $urandom_range(0, 31));

    // reset mid-layer, then out-of-range reads
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, i + 1, 0, 0);
    do_reset();
    cyc(0, 0, 1, 3, 1, 20);
    chk("t5_rd_oor", rd_data, 0);
    cyc(0, 0, 0, 0, 1, 31);
    idle(1);

    // read-before-write: addr 3 holds 7 from the previous layer
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 1, (i == 3) ? 7 : i + 20, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, i, 0, 0);
    cyc(0, 0, 1, 42, 1, 3);
    chk("t6_rbw_old", rd_data, 7);
    cyc(0, 0, 0, 0, 1, 3);
    chk("t6_rbw_new", rd_data, 42);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
